// File: rtl/multicycle_cu.sv
// ---------------------------------------------------------------------------
// multicycle_cu
//
// Multi-cycle control unit. Each instruction is walked through
// IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB (skipping the states it does
// not need). The opcode is latched when instruction memory returns it. The
// data-memory handshake in MEM gives up after MEM_TIMEOUT wait cycles.
// The unit counts retired instructions and reports illegal opcodes and
// bus errors.
//
// Parameters:
//   OPCODE_W    opcode width; legal encodings live in [3:0], upper bits must be 0
//   ALUOP_W     ALU operation bus width (>= 3)
//   MEM_TIMEOUT wait cycles allowed in MEM before a bus error (>= 1)
//   CNT_W       retired-instruction counter width
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   fetch enable, only looked at in IDLE and between instructions
//   opcode, instrValid    instruction memory return data and its valid flag
//   memReady              data memory completes the current access
//   fetchReq, pcWrite     instruction fetch request, PC load strobe
//   regDest, jump, branch, memToReg, ALUSrc   datapath mux selects
//   memRead, memWrite, regWrite               memory / register-file strobes
//   ALUOp                 ALU operation
//   illegal, busError     one-cycle error pulses
//   instrCount            retired legal instructions (wraps)
//   state                 current FSM state, for debug
// ---------------------------------------------------------------------------
module multicycle_cu #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instrValid,
  input  logic                memReady,
  output logic                fetchReq,
  output logic                pcWrite,
  output logic                regDest,
  output logic                jump,
  output logic                branch,
  output logic                memToReg,
  output logic                ALUSrc,
  output logic                memRead,
  output logic                memWrite,
  output logic                regWrite,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal,
  output logic                busError,
  output logic [CNT_W-1:0]    instrCount,
  output logic [2:0]          state
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } stateType;

  stateType curState;
  stateType nextState;
  stateType boundaryState;

  logic [OPCODE_W-1:0] opReg;
  logic [TMO_W-1:0]    tmoCnt;
  logic [3:0]          opLow;
  logic                upperSet;
  logic                countInc;
  logic [2:0]          aluOp3;

  logic isAdd, isSub, isAnd, isOr, isSlt, isLw, isSw, isBne, isJmp;
  logic isRType, isLegal;

  // Any set bit above [3:0] makes the opcode illegal; with a 4-bit opcode
  // there are no upper bits to check.
  if (OPCODE_W > 4) begin : gUpper
    assign upperSet = |opReg[OPCODE_W-1:4];
  end else begin : gNoUpper
    assign upperSet = 1'b0;
  end

  // Instruction classification from the latched opcode only, so the
  // outputs never follow the live instruction bus mid-instruction.
  assign opLow   = opReg[3:0];
  assign isAdd   = !upperSet && (opLow == 4'b0010);
  assign isSub   = !upperSet && (opLow == 4'b0110);
  assign isAnd   = !upperSet && (opLow == 4'b0000);
  assign isOr    = !upperSet && (opLow == 4'b0001);
  assign isSlt   = !upperSet && (opLow == 4'b0111);
  assign isLw    = !upperSet && (opLow == 4'b1000);
  assign isSw    = !upperSet && (opLow == 4'b1010);
  assign isBne   = !upperSet && (opLow == 4'b1110);
  assign isJmp   = !upperSet && (opLow == 4'b1111);
  assign isRType = isAdd | isSub | isAnd | isOr | isSlt;
  assign isLegal = isRType | isLw | isSw | isBne | isJmp;

  // Every exit at an instruction boundary looks at run right there; run is
  // ignored everywhere else inside an instruction.
  assign boundaryState = run ? FETCH : IDLE;

  assign ALUOp = ALUOP_W'(aluOp3);
  assign state = curState;

  // State register. Reset drops straight to IDLE, which forces every
  // decoded output low in the same instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) curState <= IDLE;
    else        curState <= nextState;
  end

  // The opcode is captured once, on the cycle instruction memory delivers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                opReg <= '0;
    else if (curState == FETCH && instrValid) opReg <= opcode;
  end

  // MEM wait counter. It is held at zero outside MEM so every MEM visit
  // starts fresh. It saturates at the limit, where the FSM leaves anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              tmoCnt <= '0;
    else if (curState != MEM)                tmoCnt <= '0;
    else if (!memReady && tmoCnt != TMO_MAX) tmoCnt <= tmoCnt + TMO_W'(1);
  end

  // Retired-instruction counter; it wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instrCount <= '0;
    else if (countInc) instrCount <= instrCount + CNT_W'(1);
  end

  // Next-state and output decode. Everything defaults low, then each state
  // raises only what it owns. pcWrite in FETCH and busError in MEM are
  // qualified by the handshake input of that cycle: the PC must step
  // exactly once per fetch, and a completion that lands on the timeout
  // cycle must win over the error.
  always_comb begin
    nextState = curState;
    fetchReq  = 1'b0;
    pcWrite   = 1'b0;
    regDest   = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    memToReg  = 1'b0;
    ALUSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    aluOp3    = 3'b000;
    illegal   = 1'b0;
    busError  = 1'b0;
    countInc  = 1'b0;

    case (curState)
      IDLE: begin
        if (run) nextState = FETCH;
      end

      FETCH: begin
        fetchReq = 1'b1;
        if (instrValid) begin
          pcWrite   = 1'b1;
          nextState = DECODE;
        end
      end

      DECODE: begin
        if (!isLegal) begin
          illegal   = 1'b1;
          nextState = boundaryState;
        end else if (isJmp) begin
          jump      = 1'b1;
          pcWrite   = 1'b1;
          regDest   = 1'b1;
          countInc  = 1'b1;
          nextState = boundaryState;
        end else begin
          nextState = EXEC;
        end
      end

      EXEC: begin
        ALUSrc = isLw | isSw;
        if (isSub || isBne) aluOp3 = 3'b001;
        else if (isAnd)     aluOp3 = 3'b010;
        else if (isOr)      aluOp3 = 3'b100;
        else if (isSlt)     aluOp3 = 3'b011;
        else                aluOp3 = 3'b000;

        if (isRType) begin
          nextState = WB;
        end else if (isLw || isSw) begin
          regDest   = 1'b1;
          nextState = MEM;
        end else begin
          // bne: the datapath gates pcWrite with the ALU zero flag.
          branch    = 1'b1;
          regDest   = 1'b1;
          pcWrite   = 1'b1;
          countInc  = isBne;
          nextState = boundaryState;
        end
      end

      MEM: begin
        regDest = 1'b1;
        ALUSrc  = 1'b1;
        if (tmoCnt != TMO_MAX) begin
          memRead  = isLw;
          memWrite = isSw;
        end
        if (memReady) begin
          if (isLw) begin
            nextState = WB;
          end else begin
            countInc  = isSw;
            nextState = boundaryState;
          end
        end else if (tmoCnt == TMO_MAX) begin
          busError  = 1'b1;
          nextState = boundaryState;
        end
      end

      WB: begin
        regWrite  = 1'b1;
        memToReg  = isLw;
        regDest   = isLw;
        countInc  = 1'b1;
        nextState = boundaryState;
      end

      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_cu
//
// Directed bench for multicycle_cu. The DUT is built with a 5-bit opcode, so
// upper-bit illegals can be reached, and a 4-bit counter, so wrap is cheap to
// reach. Each cycle the bench pushes the expected output vector into a queue
// as it drives the inputs. It pops that vector and compares it against the
// DUT in the middle of the cycle, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_cu;

  localparam int OPW = 5;
  localparam int AW  = 3;
  localparam int TMO = 15;
  localparam int CW  = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic           instrValid = 1'b0;
  logic           memReady = 1'b0;
  logic           fetchReq, pcWrite, regDest, jump, branch, memToReg, ALUSrc;
  logic           memRead, memWrite, regWrite, illegal, busError;
  logic [AW-1:0]  ALUOp;
  logic [CW-1:0]  instrCount;
  logic [2:0]     state;

  multicycle_cu #(
    .OPCODE_W(OPW), .ALUOP_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .instrValid(instrValid), .memReady(memReady),
    .fetchReq(fetchReq), .pcWrite(pcWrite), .regDest(regDest),
    .jump(jump), .branch(branch), .memToReg(memToReg), .ALUSrc(ALUSrc),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .ALUOp(ALUOp), .illegal(illegal), .busError(busError),
    .instrCount(instrCount), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          fetchReq, pcWrite, regDest, jump, branch, memToReg;
    logic          aluSrc, memRead, memWrite, regWrite;
    logic [AW-1:0] aluOp;
    logic          illegal, busError;
    logic [CW-1:0] cnt;
  } vecT;

  vecT           expQ[$];
  int            checkCount = 0;
  int            passCount = 0;
  int            failCount = 0;
  logic [2:0]    expState = S_IDLE;
  logic [CW-1:0] expCount = '0;

  // Expected vector with every strobe low, in the modelled state and count.
  function automatic vecT blank();
    vecT v = '0;
    v.st  = expState;
    v.cnt = expCount;
    return v;
  endfunction

  function automatic vecT observed();
    vecT v;
    v.st = state;         v.fetchReq = fetchReq; v.pcWrite = pcWrite;
    v.regDest = regDest;  v.jump = jump;         v.branch = branch;
    v.memToReg = memToReg; v.aluSrc = ALUSrc;    v.memRead = memRead;
    v.memWrite = memWrite; v.regWrite = regWrite; v.aluOp = ALUOp;
    v.illegal = illegal;  v.busError = busError; v.cnt = instrCount;
    return v;
  endfunction

  function automatic logic [2:0] expAlu(input logic [3:0] lo);
    case (lo)
      4'b0110: return 3'b001;
      4'b0000: return 3'b010;
      4'b0001: return 3'b100;
      4'b0111: return 3'b011;
      4'b1110: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput(input string tag);
    vecT e;
    vecT o;
    e = expQ.pop_front();
    o = observed();
    checkCount++;
    assert (o === e) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed state=%0d vec=%h, expected state=%0d vec=%h",
             tag, o.st, o, e.st, e);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, queue the expectation,
  // then check once the combinational outputs have settled.
  task automatic applyStimulus(input logic r, input logic iv, input logic [OPW-1:0] op,
                               input logic mr, input vecT e, input string tag);
    @(negedge clk);
    run = r; instrValid = iv; opcode = op; memReady = mr;
    expQ.push_back(e);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input logic r, input string tag);
    applyStimulus(r, 1'b0, OPW'($urandom), 1'b0, blank(), tag);
    if (r) expState = S_FETCH;
  endtask

  // One full instruction starting in FETCH. memWait < 0 means memReady never
  // comes. run is 0 from cycle index runOffAt on. resetAt >= 0 asserts rst_n
  // after that MEM cycle.
  task automatic runInstr(input logic [OPW-1:0] op, input int fetchWait, input int memWait,
                          input int runOffAt, input int resetAt, input string tag);
    int c = 0;
    vecT e;
    logic r;
    logic mr;
    logic [3:0] lo = op[3:0];
    logic upper = (op[OPW-1:4] != '0);
    logic isR   = !upper && (lo inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111});
    logic isLw  = !upper && (lo == 4'b1000);
    logic isSw  = !upper && (lo == 4'b1010);
    logic isBne = !upper && (lo == 4'b1110);
    logic isJmp = !upper && (lo == 4'b1111);
    logic legal = isR | isLw | isSw | isBne | isJmp;

    for (int i = 0; i < fetchWait; i++) begin
      r = (c < runOffAt);
      e = blank(); e.fetchReq = 1'b1;
      applyStimulus(r, 1'b0, OPW'($urandom), 1'b0, e, {tag, " fetch-wait"});
      c++;
    end
    r = (c < runOffAt);
    e = blank(); e.fetchReq = 1'b1; e.pcWrite = 1'b1;
    applyStimulus(r, 1'b1, op, 1'b0, e, {tag, " fetch"});
    c++;
    expState = S_DECODE;

    r = (c < runOffAt);
    e = blank();
    if (!legal) e.illegal = 1'b1;
    else if (isJmp) begin e.jump = 1'b1; e.pcWrite = 1'b1; e.regDest = 1'b1; end
    applyStimulus(r, 1'b0, OPW'($urandom), 1'b0, e, {tag, " decode"});
    c++;
    if (!legal || isJmp) begin
      if (isJmp) expCount++;
      expState = r ? S_FETCH : S_IDLE;
      return;
    end
    expState = S_EXEC;

    r = (c < runOffAt);
    e = blank();
    e.aluOp  = expAlu(lo);
    e.aluSrc = isLw | isSw;
    if (isLw || isSw) e.regDest = 1'b1;
    if (isBne) begin e.branch = 1'b1; e.regDest = 1'b1; e.pcWrite = 1'b1; end
    applyStimulus(r, 1'b0, OPW'($urandom), 1'b0, e, {tag, " exec"});
    c++;
    if (isBne) begin
      expCount++;
      expState = r ? S_FETCH : S_IDLE;
      return;
    end
    expState = isR ? S_WB : S_MEM;

    if (!isR) begin
      for (int k = 0; k <= TMO; k++) begin
        r  = (c < runOffAt);
        mr = (k == memWait);
        e  = blank(); e.regDest = 1'b1; e.aluSrc = 1'b1;
        if (k < TMO) begin e.memRead = isLw; e.memWrite = isSw; end
        if (!mr && k == TMO) e.busError = 1'b1;
        applyStimulus(r, 1'b0, OPW'($urandom), mr, e, {tag, " mem"});
        c++;
        if (k == resetAt) begin
          rst_n = 1'b0;
          #1;
          expState = S_IDLE;
          expCount = '0;
          expQ.push_back(blank());
          checkOutput({tag, " reset-in-mem"});
          return;
        end
        if (mr) begin
          if (isLw) begin
            expState = S_WB;
            break;
          end
          expCount++;
          expState = r ? S_FETCH : S_IDLE;
          return;
        end
        if (k == TMO) begin
          expState = r ? S_FETCH : S_IDLE;
          return;
        end
      end
    end

    r = (c < runOffAt);
    e = blank(); e.regWrite = 1'b1; e.memToReg = isLw; e.regDest = isLw;
    applyStimulus(r, 1'b0, OPW'($urandom), 1'b0, e, {tag, " wb"});
    expCount++;
    expState = r ? S_FETCH : S_IDLE;
  endtask

  initial begin
    // Reset held: everything low, state IDLE.
    #2;
    expQ.push_back(blank());
    checkOutput("in-reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idleCycle(1'b0, "idle run=0");

    // Start fetching, then a mix of instruction types.
    idleCycle(1'b1, "idle run=1");
    runInstr(5'b00010, 0, 0, 99, -1, "add");
    runInstr(5'b01000, 0, 3, 99, -1, "lw wait3");
    runInstr(5'b01010, 0, 3, 99, -1, "sw wait3");
    runInstr(5'b01010, 0, -1, 99, -1, "sw timeout");
    runInstr(5'b01010, 0, TMO, 99, -1, "sw ready-at-limit");
    runInstr(5'b01000, 1, 0, 99, -1, "lw immediate");
    runInstr(5'b00011, 0, 0, 99, -1, "illegal 0011");
    runInstr(5'b10010, 0, 0, 99, -1, "illegal upper bit");
    runInstr(5'b01111, 0, 0, 99, -1, "jmp");
    runInstr(5'b01110, 0, 0, 99, -1, "bne");
    runInstr(5'b00001, 2, 0, 99, -1, "or");
    runInstr(5'b00000, 1, 0, 99, -1, "and");
    runInstr(5'b00111, 0, 0, 99, -1, "slt");

    // run drops in EXEC: sub still writes back, then the FSM parks in IDLE.
    runInstr(5'b00110, 0, 0, 2, -1, "sub run-drop");
    idleCycle(1'b0, "idle after sub");

    // Reset pulsed in the middle of a load's MEM wait.
    idleCycle(1'b1, "idle run=1 pre-lw");
    runInstr(5'b01000, 0, -1, 99, 1, "lw aborted");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle(1'b0, "idle after abort");

    // 17 retired instructions on a 4-bit counter wrap it to 1.
    idleCycle(1'b1, "idle run=1 wrap");
    for (int i = 0; i < 17; i++) runInstr(5'b00010, 0, 0, (i == 16) ? 3 : 99, -1, "add wrap");
    idleCycle(1'b0, "idle after wrap");
    checkCount++;
    assert (instrCount === 4'd1) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL wrap-count: observed=%0d expected=1", instrCount);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
